// File: rtl/sys_bus_rr_arbiter.sv
// Round-robin arbiter sharing one system-bus master port among N strobe-driven requesters.
// One transaction in flight at a time; a watchdog force-completes with err when the slave never acks.
module sys_bus_rr_arbiter #(
  parameter int N       = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N*AW-1:0]       req_addr_i,
  input  logic [N*DW-1:0]       req_wdata_i,
  input  logic [N*(DW/8)-1:0]   req_sel_i,
  input  logic [N-1:0]          req_wen_i,
  input  logic [N-1:0]          req_ren_i,
  output logic [N-1:0]          req_ack_o,
  output logic [N-1:0]          req_err_o,
  output logic [DW-1:0]         req_rdata_o,
  output logic [N-1:0]          req_ovf_o,
  output logic [AW-1:0]         m_addr_o,
  output logic [DW-1:0]         m_wdata_o,
  output logic [DW/8-1:0]       m_sel_o,
  output logic                  m_wen_o,
  output logic                  m_ren_o,
  input  logic [DW-1:0]         m_rdata_i,
  input  logic                  m_ack_i,
  input  logic                  m_err_i,
  output logic                  busy_o
);
  localparam int SW = DW / 8;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           pend_q, pend_d;
  logic [N-1:0]           ovf_q, ovf_d;
  logic [N-1:0]           slot_wr_q, slot_wr_d;
  logic [N-1:0][AW-1:0]   slot_addr_q, slot_addr_d;
  logic [N-1:0][DW-1:0]   slot_wdata_q, slot_wdata_d;
  logic [N-1:0][SW-1:0]   slot_sel_q, slot_sel_d;
  logic [PW-1:0]          ptr_q, ptr_d, g_q, g_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [AW-1:0]          m_addr_q, m_addr_d;
  logic [DW-1:0]          m_wdata_q, m_wdata_d;
  logic [SW-1:0]          m_sel_q, m_sel_d;
  logic                   m_wen_q, m_wen_d, m_ren_q, m_ren_d;
  logic [N-1:0]           ack_q, ack_d, err_q, err_d;
  logic [DW-1:0]          rdata_q, rdata_d;

  logic [PW-1:0]          pick;
  logic                   found;
  logic                   in_flight;

  // First pending slot at or after the pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && pend_q[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + i) % N);
      end
    end
  end

  // The granted port stays blocked until its RESP cycle, where a new strobe is allowed.
  assign in_flight = (state_q == S_ISSUE) || (state_q == S_WAIT);

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    ovf_d        = ovf_q;
    slot_wr_d    = slot_wr_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_sel_d   = slot_sel_q;
    ptr_d        = ptr_q;
    g_d          = g_q;
    cnt_d        = cnt_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_sel_d      = m_sel_q;
    m_wen_d      = 1'b0;
    m_ren_d      = 1'b0;
    ack_d        = '0;
    err_d        = '0;
    rdata_d      = rdata_q;

    for (int k = 0; k < N; k++) begin
      if (req_wen_i[k] || req_ren_i[k]) begin
        if (pend_q[k] || (in_flight && g_q == PW'(k))) begin
          ovf_d[k] = 1'b1;
        end else begin
          pend_d[k]       = 1'b1;
          slot_wr_d[k]    = req_wen_i[k];
          slot_addr_d[k]  = req_addr_i[k*AW +: AW];
          slot_wdata_d[k] = req_wdata_i[k*DW +: DW];
          slot_sel_d[k]   = req_sel_i[k*SW +: SW];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d       = pick;
          ptr_d     = (pick == PW'(N - 1)) ? '0 : pick + 1'b1;
          m_addr_d  = slot_addr_q[pick];
          m_wdata_d = slot_wdata_q[pick];
          m_sel_d   = slot_sel_q[pick];
          m_wen_d   = slot_wr_q[pick];
          m_ren_d   = !slot_wr_q[pick];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pend_d[g_q] = 1'b0;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A real ack beats the watchdog when both land in the same cycle.
        if (m_ack_i) begin
          ack_d[g_q] = 1'b1;
          err_d[g_q] = m_err_i;
          rdata_d    = m_rdata_i;
          state_d    = S_RESP;
        end else if (cnt_q == TMO_LAST) begin
          ack_d[g_q] = 1'b1;
          err_d[g_q] = 1'b1;
          rdata_d    = '0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      ovf_q        <= '0;
      slot_wr_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_sel_q   <= '0;
      ptr_q        <= '0;
      g_q          <= '0;
      cnt_q        <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_sel_q      <= '0;
      m_wen_q      <= 1'b0;
      m_ren_q      <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      slot_wr_q    <= slot_wr_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_sel_q   <= slot_sel_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      cnt_q        <= cnt_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_sel_q      <= m_sel_d;
      m_wen_q      <= m_wen_d;
      m_ren_q      <= m_ren_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ack_o   = ack_q;
  assign req_err_o   = err_q;
  assign req_rdata_o = rdata_q;
  assign req_ovf_o   = ovf_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign m_sel_o     = m_sel_q;
  assign m_wen_o     = m_wen_q;
  assign m_ren_o     = m_ren_q;
  assign busy_o      = (state_q != S_IDLE) || (|pend_q);

endmodule

// File: tb/tb_sys_bus_rr_arbiter.sv
// Bench for sys_bus_rr_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_sys_bus_rr_arbiter;
  localparam int N = 4, AW = 32, DW = 32, SW = 4, TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_sel;
  logic [N-1:0]    req_wen, req_ren;
  logic [N-1:0]    req_ack, req_err, req_ovf;
  logic [DW-1:0]   req_rdata;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [SW-1:0]   m_sel;
  logic            m_wen, m_ren, m_ack, m_err, busy;

  sys_bus_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .TMO_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .req_wen_i(req_wen), .req_ren_i(req_ren),
    .req_ack_o(req_ack), .req_err_o(req_err), .req_rdata_o(req_rdata), .req_ovf_o(req_ovf),
    .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_sel_o(m_sel), .m_wen_o(m_wen), .m_ren_o(m_ren),
    .m_rdata_i(m_rdata), .m_ack_i(m_ack), .m_err_i(m_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Transaction-level model: pending set, pointer, and the one transaction in flight
  // described by the cycle it hits the bus and the cycle its response is returned.
  bit [N-1:0]    mp;
  logic [AW-1:0] ma [N];
  logic [DW-1:0] mw [N];
  logic [SW-1:0] ms [N];
  bit            mwr [N];
  int            mptr, mcur, missue, mresp;
  bit            merr, cur_wr;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwdata, e_rdata;
  logic [SW-1:0] e_msel;
  bit [N-1:0]    e_ovf;

  // Slave behaviour
  int            slv_delay, cd;
  logic [DW-1:0] slv_rdata;
  bit            slv_err, force_ack, rand_slave;

  typedef struct { int c; logic [AW-1:0] a; bit w; } iss_t;
  typedef struct { int c; logic [N-1:0] ack; logic [N-1:0] err; logic [DW-1:0] rd; } ack_t;
  iss_t iss_log[$];
  ack_t ack_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mp = '0; mptr = 0; mcur = -1; missue = -1; mresp = -1; merr = 0; cur_wr = 0;
    e_maddr = '0; e_mwdata = '0; e_msel = '0; e_rdata = '0; e_ovf = '0;
    for (int i = 0; i < N; i++) begin ma[i] = '0; mw[i] = '0; ms[i] = '0; mwr[i] = 0; end
  endtask

  task automatic compare_outputs();
    logic [N-1:0] e_ack, e_err;
    bit e_wen, e_ren;
    e_ack = '0; e_err = '0; e_wen = 0; e_ren = 0;
    if (mcur >= 0) begin
      if (cyc == missue) begin e_wen = cur_wr; e_ren = !cur_wr; end
      if (cyc == mresp) begin e_ack[mcur] = 1'b1; e_err[mcur] = merr; end
    end
    chk("m_wen", m_wen, e_wen);
    chk("m_ren", m_ren, e_ren);
    chk("m_addr", m_addr, e_maddr);
    chk("m_wdata", m_wdata, e_mwdata);
    chk("m_sel", m_sel, e_msel);
    chk("req_ack", req_ack, e_ack);
    chk("req_err", req_err, e_err);
    chk("req_rdata", req_rdata, e_rdata);
    chk("req_ovf", req_ovf, e_ovf);
    chk("busy", busy, (mcur >= 0) || (mp != 0));
    if (m_wen || m_ren) iss_log.push_back('{cyc, m_addr, m_wen});
    if (req_ack != '0) ack_log.push_back('{cyc, req_ack, req_err, req_rdata});
  endtask

  task automatic model_update();
    bit [N-1:0] blocked;
    int k;
    if (rst) begin model_reset(); return; end
    for (int i = 0; i < N; i++)
      blocked[i] = mp[i] || (mcur == i && (mresp < 0 || cyc < mresp));
    if (mcur >= 0) begin
      if (mresp >= 0 && cyc == mresp) mcur = -1;
      else if (mresp < 0 && cyc > missue) begin
        if (m_ack) begin mresp = cyc + 1; merr = m_err; e_rdata = m_rdata; end
        else if (cyc - missue == TMO) begin mresp = cyc + 1; merr = 1; e_rdata = '0; end
      end
    end else if (mp != '0) begin
      for (int i = 0; i < N; i++) begin
        k = (mptr + i) % N;
        if (mp[k] && mcur < 0) mcur = k;
      end
      missue = cyc + 1; mresp = -1; mp[mcur] = 0; mptr = (mcur + 1) % N;
      e_maddr = ma[mcur]; e_mwdata = mw[mcur]; e_msel = ms[mcur]; cur_wr = mwr[mcur];
    end
    for (int i = 0; i < N; i++) begin
      if (req_wen[i] || req_ren[i]) begin
        if (blocked[i]) e_ovf[i] = 1'b1;
        else begin
          mp[i] = 1'b1; mwr[i] = req_wen[i];
          ma[i] = req_addr[i*AW +: AW]; mw[i] = req_wdata[i*DW +: DW]; ms[i] = req_sel[i*SW +: SW];
        end
      end
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = $urandom();
      req_wdata[i*DW +: DW] = $urandom();
      req_sel[i*SW +: SW]   = SW'($urandom_range(15, 0));
    end
  endtask

  // One clock cycle: check outputs, drive the slave, advance the model.
  task automatic step();
    compare_outputs();
    m_ack = 1'b0; m_err = 1'b0; m_rdata = $urandom();
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin m_ack = 1'b1; m_err = slv_err; m_rdata = slv_rdata; end
    end
    if (force_ack) begin m_ack = 1'b1; m_err = 1'($urandom_range(1, 0)); end
    if (m_wen || m_ren) begin
      if (rand_slave) begin
        slv_delay = $urandom_range(10, 0);
        slv_rdata = $urandom();
        slv_err   = 1'($urandom_range(1, 0));
      end
      cd = slv_delay;
    end
    model_update();
    @(negedge clk);
    cyc++;
    req_wen = '0; req_ren = '0; force_ack = 0; rst = 1'b0;
    randomize_data();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
  endtask

  task automatic clear_logs();
    iss_log.delete();
    ack_log.delete();
  endtask

  initial begin
    int t0;
    rst = 1'b1; req_wen = '0; req_ren = '0; m_ack = 0; m_err = 0; m_rdata = '0;
    force_ack = 0; rand_slave = 0; slv_delay = 0; cd = 0; slv_rdata = '0; slv_err = 0;
    randomize_data();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("reset_busy", busy, 0);
    chk("reset_ovf", req_ovf, 0);
    chk("reset_ack", req_ack, 0);

    // Single read on port 2, slave acks 3 cycles after m_ren
    clear_logs(); t0 = cyc;
    slv_delay = 3; slv_rdata = 32'h1234_5678; slv_err = 0;
    req_ren[2] = 1'b1; req_addr[2*AW +: AW] = 32'hA000_0002;
    step(); repeat (10) step();
    chk("t1_iss_n", iss_log.size(), 1);
    if (iss_log.size() >= 1) begin
      chk("t1_iss_cyc", iss_log[0].c - t0, 2);
      chk("t1_iss_addr", iss_log[0].a, 32'hA000_0002);
      chk("t1_iss_wen", iss_log[0].w, 0);
    end
    chk("t1_ack_n", ack_log.size(), 1);
    if (ack_log.size() >= 1) begin
      chk("t1_ack_cyc", ack_log[0].c - t0, 6);
      chk("t1_ack_vec", ack_log[0].ack, 4'b0100);
      chk("t1_ack_err", ack_log[0].err, 0);
      chk("t1_rdata", ack_log[0].rd, 32'h1234_5678);
    end

    // All four ports write together from ptr=0, immediate ack
    do_reset(); clear_logs(); t0 = cyc;
    slv_delay = 1;
    for (int k = 0; k < N; k++) req_addr[k*AW +: AW] = 32'hB000_0000 + k;
    req_wen = '1;
    step(); repeat (24) step();
    chk("t2_iss_n", iss_log.size(), 4);
    chk("t2_ack_n", ack_log.size(), 4);
    for (int k = 0; k < N; k++) begin
      if (iss_log.size() > k) begin
        chk("t2_iss_addr", iss_log[k].a, 32'hB000_0000 + k);
        chk("t2_iss_cyc", iss_log[k].c - t0, 2 + 4 * k);
      end
      if (ack_log.size() > k) chk("t2_ack_vec", ack_log[k].ack, 64'(1) << k);
    end
    chk("t2_ovf", req_ovf, 0);

    // Port 1 strobes again while pending
    clear_logs(); slv_delay = 2;
    req_wen[1] = 1'b1; req_addr[1*AW +: AW] = 32'hC000_0001;
    step();
    req_wen[1] = 1'b1; req_addr[1*AW +: AW] = 32'hC000_00FF;
    step(); repeat (12) step();
    chk("t3_ovf", req_ovf, 4'b0010);
    chk("t3_iss_n", iss_log.size(), 1);
    if (iss_log.size() >= 1) chk("t3_iss_addr", iss_log[0].a, 32'hC000_0001);
    repeat (5) step();
    chk("t3_ovf_sticky", req_ovf, 4'b0010);

    // Re-strobe in the RESP cycle is accepted
    do_reset(); clear_logs(); t0 = cyc; slv_delay = 1;
    req_wen[0] = 1'b1; req_addr[0 +: AW] = 32'hD000_0000;
    repeat (4) step();
    req_ren[0] = 1'b1; req_addr[0 +: AW] = 32'hD000_0001;
    step(); repeat (8) step();
    chk("t3b_iss_n", iss_log.size(), 2);
    if (iss_log.size() >= 2) begin
      chk("t3b_iss_cyc", iss_log[1].c - t0, 6);
      chk("t3b_iss_addr", iss_log[1].a, 32'hD000_0001);
      chk("t3b_iss_wen", iss_log[1].w, 0);
    end
    chk("t3b_ovf", req_ovf, 0);

    // Timeout on a read from port 0, late ack ignored, next grant proceeds
    clear_logs(); t0 = cyc; slv_delay = 0;
    req_ren[0] = 1'b1; req_addr[0 +: AW] = 32'hE000_0000;
    repeat (12) step();
    force_ack = 1;
    step();
    slv_delay = 1; slv_err = 0; slv_rdata = 32'h5555_AAAA;
    req_wen[3] = 1'b1; req_addr[3*AW +: AW] = 32'hE000_0003;
    step(); repeat (8) step();
    chk("t4_iss_n", iss_log.size(), 2);
    chk("t4_ack_n", ack_log.size(), 2);
    if (iss_log.size() >= 2) begin
      chk("t4_iss0_cyc", iss_log[0].c - t0, 2);
      chk("t4_iss1_cyc", iss_log[1].c - t0, 15);
      chk("t4_iss1_addr", iss_log[1].a, 32'hE000_0003);
    end
    if (ack_log.size() >= 2) begin
      chk("t4_tmo_cyc", ack_log[0].c - t0, 11);
      chk("t4_tmo_vec", ack_log[0].ack, 4'b0001);
      chk("t4_tmo_err", ack_log[0].err, 4'b0001);
      chk("t4_tmo_rdata", ack_log[0].rd, 0);
      chk("t4_next_cyc", ack_log[1].c - t0, 17);
      chk("t4_next_vec", ack_log[1].ack, 4'b1000);
      chk("t4_next_err", ack_log[1].err, 0);
    end

    // Reset in WAIT with port 3 in flight and port 1 pending
    do_reset(); clear_logs(); slv_delay = 0;
    req_wen[3] = 1'b1; req_addr[3*AW +: AW] = 32'hF300_0000;
    step();
    req_ren[1] = 1'b1; req_addr[1*AW +: AW] = 32'hF100_0000;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("t5_addr_zero", m_addr, 0);
    chk("t5_busy_zero", busy, 0);
    force_ack = 1;
    step(); repeat (3) step();
    chk("t5_no_ack", ack_log.size(), 0);
    chk("t5_busy_idle", busy, 0);
    clear_logs(); slv_delay = 1;
    req_wen[3] = 1'b1; req_addr[3*AW +: AW] = 32'hF300_0001;
    req_wen[1] = 1'b1; req_addr[1*AW +: AW] = 32'hF100_0001;
    step(); repeat (12) step();
    chk("t5_iss_n", iss_log.size(), 2);
    if (iss_log.size() >= 2) begin
      chk("t5_first", iss_log[0].a, 32'hF100_0001);
      chk("t5_second", iss_log[1].a, 32'hF300_0001);
    end

    // Ack coincides with the timeout: ack wins, err and rdata from the slave
    for (int j = 0; j < 2; j++) begin
      clear_logs(); t0 = cyc; slv_delay = TMO;
      slv_err = (j == 0); slv_rdata = (j == 0) ? 32'hCAFE_F00D : 32'h0BAD_BEEF;
      req_ren[2] = 1'b1; req_addr[2*AW +: AW] = 32'h6000_0002;
      step(); repeat (12) step();
      chk("t6_ack_n", ack_log.size(), 1);
      if (ack_log.size() >= 1) begin
        chk("t6_cyc", ack_log[0].c - t0, 11);
        chk("t6_err", ack_log[0].err, (j == 0) ? 4'b0100 : 4'b0000);
        chk("t6_rdata", ack_log[0].rd, (j == 0) ? 32'hCAFE_F00D : 32'h0BAD_BEEF);
      end
    end

    // Random traffic
    rand_slave = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(99, 0) < 12) begin
          case ($urandom_range(2, 0))
            0: req_wen[k] = 1'b1;
            1: req_ren[k] = 1'b1;
            default: begin req_wen[k] = 1'b1; req_ren[k] = 1'b1; end
          endcase
        end
      end
      if ($urandom_range(99, 0) < 3) force_ack = 1;
      if ($urandom_range(999, 0) < 4) rst = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
